// File: rtl/ball_uart_tx.sv
// ============================================================================
// Module   : ball_uart_tx
// Purpose  : Buffered 8N1 serial transmitter (valid/ready byte FIFO + shifter)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_div_w = $clog2(CLK_DIV);

  localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);
  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_q,   state_d;
  logic [c_div_w-1:0]   div_q,     div_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q,   shift_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;
  logic [c_ptr_w-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [c_ptr_w-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [c_lvl_w-1:0]   level_q,   level_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [7:0]           mem_d [FIFO_DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic                 w_start_ok;
  logic                 w_div_end;

  // Ready depends on the registered level only, so a full FIFO refuses a
  // push even on the cycle a frame boundary pops the head.
  assign in_ready   = (level_q < c_depth);
  assign w_push     = in_valid && in_ready;
  assign w_start_ok = (level_q != '0) && ena;
  assign w_div_end  = (div_q == c_div_last);

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + c_div_one;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    w_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (w_start_ok) begin
          w_pop   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (w_div_end) begin
          div_d     = '0;
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        if (w_div_end) begin
          div_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end

      ST_STOP: begin
        if (w_div_end) begin
          div_d = '0;
          // Chain straight into the next start bit to avoid an idle gap.
          if (w_start_ok) begin
            w_pop   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (w_push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + c_ptr_one;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_lvl_one;
      2'b01:   level_d = level_q - c_lvl_one;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ball_uart_tx.sv
// ============================================================================
// Module   : tb_ball_uart_tx
// Purpose  : Self-checking bench for ball_uart_tx against a frame-timeline model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'd0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic [5:0] dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  ball_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  assign dut_vec = {tx, busy, in_ready, fifo_level};

  // Reference: a queue of accepted bytes plus the cycle offset into the
  // current frame; the line level is derived from offset / CLK_DIV.
  logic [7:0] m_q [$];
  bit         m_in_frame = 1'b0;
  int         m_fcnt     = 0;
  logic [7:0] m_cur      = 8'd0;
  int         m_accepts  = 0;

  task automatic model_reset();
    m_q.delete();
    m_in_frame = 1'b0;
    m_fcnt     = 0;
    m_cur      = 8'd0;
  endtask

  task automatic model_step();
    bit acc, ends, start;
    acc   = in_valid && (m_q.size() < FIFO_DEPTH);
    ends  = m_in_frame && (m_fcnt == FRAME - 1);
    start = (!m_in_frame || ends) && (m_q.size() > 0) && ena;
    if (start) begin
      m_cur      = m_q.pop_front();
      m_in_frame = 1'b1;
      m_fcnt     = 0;
    end else if (ends) begin
      m_in_frame = 1'b0;
    end else if (m_in_frame) begin
      m_fcnt++;
    end
    if (acc) begin
      m_q.push_back(in_data);
      m_accepts++;
    end
  endtask

  function automatic logic [5:0] model_vec();
    int   slot;
    logic line;
    slot = m_fcnt / CLK_DIV;
    if (!m_in_frame)    line = 1'b1;
    else if (slot == 0) line = 1'b0;
    else if (slot == 9) line = 1'b1;
    else                line = m_cur[slot-1];
    return {line, m_in_frame, (m_q.size() < FIFO_DEPTH), 3'(m_q.size())};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int hi = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_values: got %b want %b", dut_vec, 6'b101000);
    end
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (tx === 1'b1) hi++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (hi !== 100) begin
      n_fail++;
      $display("FAIL reset_tx_high: got %0d cycles want 100", hi);
    end
  endtask

  task automatic test_single_byte();
    logic       samp [60];
    logic [9:0] exp_line;
    int         busy_cyc = 0;
    exp_line = 10'b1010010110;
    in_data  = 8'h4B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (dut_vec !== 6'b101001) begin
      n_fail++;
      $display("FAIL single_after_push: got %b want %b", dut_vec, 6'b101001);
    end
    for (int c = 0; c < 60; c++) begin
      in_data = 8'($urandom);
      tick();
      samp[c] = tx;
      if (busy === 1'b1) busy_cyc++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL single_model cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (samp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_tx_fall: got %b want 0", samp[0]);
    end
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (samp[b*CLK_DIV+2] !== exp_line[b]) begin
        n_fail++;
        $display("FAIL single_bit %0d: got %b want %b", b, samp[b*CLK_DIV+2], exp_line[b]);
      end
    end
    n_cmp++;
    if (busy_cyc !== 40) begin
      n_fail++;
      $display("FAIL single_busy_len: got %0d want 40", busy_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    int         acc0;
    int         busy_cyc = 0;
    bytes = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h31};
    acc0  = m_accepts;
    for (int i = 0; i < 5; i++) begin
      in_data  = bytes[i];
      in_valid = 1'b1;
      tick();
      if (busy === 1'b1) busy_cyc++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL b2b_push %0d: got %b want %b", i, dut_vec, model_vec());
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({in_ready, fifo_level} !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_full: got ready=%b level=%0d want ready=0 level=4", in_ready, fifo_level);
    end
    for (int c = 0; c < 220; c++) begin
      tick();
      if (busy === 1'b1) busy_cyc++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL b2b_model cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (busy_cyc !== FRAME * (m_accepts - acc0)) begin
      n_fail++;
      $display("FAIL b2b_busy_total: got %0d want %0d", busy_cyc, FRAME * (m_accepts - acc0));
    end
  endtask

  task automatic test_full_pop();
    int found = -1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    for (int c = 0; c < 60 && found < 0; c++) begin
      in_data = 8'($urandom);
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL fullpop_model cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
      if (fifo_level === 3'd3) found = c;
    end
    n_cmp++;
    if (found !== 36) begin
      n_fail++;
      $display("FAIL fullpop_drop: level 3 seen at %0d want 36", found);
    end
    in_data = 8'($urandom);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpop_accept_next: got %0d want 4", fifo_level);
    end
    for (int c = 0; c < 220; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL fullpop_drain cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_ena_gating();
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    tick();
    in_data  = 8'($urandom);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) ena = 1'b0;
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL ena_model cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (dut_vec !== 6'b101001) begin
      n_fail++;
      $display("FAIL ena_parked: got %b want %b", dut_vec, 6'b101001);
    end
    ena = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec !== 6'b011000) begin
      n_fail++;
      $display("FAIL ena_resume: got %b want %b", dut_vec, 6'b011000);
    end
    for (int c = 0; c < 50; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL ena_drain cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int hi = 0;
    in_valid = 1'b1;
    in_data  = 8'($urandom) & 8'hF7;
    tick();
    in_data  = 8'($urandom);
    tick();
    in_data  = 8'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    n_cmp++;
    if ({tx, busy, fifo_level} !== 5'b01010) begin
      n_fail++;
      $display("FAIL rstmid_bit3: got tx=%b busy=%b level=%0d want tx=0 busy=1 level=2", tx, busy, fifo_level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 6'b101000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want %b", dut_vec, 6'b101000);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tx === 1'b1) hi++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL rstmid_after cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (hi !== 60) begin
      n_fail++;
      $display("FAIL rstmid_no_residual: tx high %0d cycles want 60", hi);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      ena      = ($urandom_range(0, 7) != 0);
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    for (int c = 0; c < 220; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_drain cyc %0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_pop();
    test_ena_gating();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ball_uart_tx.md
# ball_uart_tx

Buffered 8N1 serial transmitter for the tt09ball output path. Upstream logic pushes bytes through a valid/ready port into a small FIFO. The block serializes each byte LSB-first onto a single output pin for `uo_out` at a fixed divided bit rate. It is the transmit counterpart of the input-side handling of `ui_in` at the top level, and it lets the answer text be streamed to a host or terminal.

## Interface

**Parameters**
- `CLK_DIV`, default 16: clock cycles per serial bit. Legal values are at least 2.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Power of 2, at least 2.

**Ports**
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: asynchronous active-low reset.
- `ena`, input, 1: design enable. While low, no new frame starts. A frame already in progress completes.
- `in_data`, input, 8: byte to transmit.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: FIFO can accept a byte.
- `tx`, output, 1: serial line. Idles high.
- `busy`, output, 1: a frame is in progress.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1`: number of bytes queued. This count excludes the byte currently being shifted.

## Operation

**Reset**
- Outputs while reset is asserted: `tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0.
- Reset clears the FIFO and the pointers. It sets the state to IDLE and clears the bit counter and the divider counter.

**FIFO**
- A push happens at a rising edge where `in_valid && in_ready`.
- `in_ready` = (`fifo_level` < `FIFO_DEPTH`). It is combinational from `fifo_level` only.
- When the FIFO is full, a push is refused even if a pop happens in the same cycle.
- Simultaneous push and pop with the FIFO not full: the level is unchanged and both operations take effect.
- Pointers wrap modulo `FIFO_DEPTH`.

**State machine: IDLE, START, DATA, STOP**
- IDLE → START when `fifo_level` > 0 and `ena`=1.
  - On that edge, pop the head byte into the shift register.
  - `fifo_level` decrements on the same edge, unless a push also happens.
- START: `tx`=0 for `CLK_DIV` cycles. Then go to DATA with bit index 0.
- DATA: `tx` = shift bit 0 for `CLK_DIV` cycles, then shift right.
  - After 8 bits, go to STOP.
  - The bit index counts 0..7 in 3 bits and never wraps mid-frame.
- STOP: `tx`=1 for `CLK_DIV` cycles. At the end of the stop bit:
  - If the FIFO is non-empty and `ena`=1, go directly to START and pop. There is no idle gap.
  - Otherwise go to IDLE.
- Divider: a counter runs 0..`CLK_DIV`-1 and is reset to 0 on every state entry.

**Outputs**
- `busy`=1 in every state except IDLE.
- `tx` comes straight from a flop, so it is glitch-free.

**Boundary conditions**
- `ena` dropped mid-frame: the frame finishes normally. The machine then parks in IDLE with the FIFO contents retained.
- `in_data` is sampled only at the push edge. Changes at any other time are ignored.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and the queued bytes are discarded.

## Timing

- Push at edge N with the FIFO empty and the block idle:
  - `fifo_level`=1 after edge N.
  - The pop and START entry happen at edge N+1: `tx` falls, `busy` rises, and `fifo_level` returns to 0.
- Frame length is exactly 10×`CLK_DIV` cycles:
  - Start bit: cycles 0..`CLK_DIV`-1.
  - Data bit k: cycles (k+1)·`CLK_DIV` .. (k+2)·`CLK_DIV`-1.
  - Stop bit: cycles 9·`CLK_DIV` .. 10·`CLK_DIV`-1.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the edge that ends the stop bit when no further byte is pending.
- Sustained throughput: one byte per 10×`CLK_DIV` cycles.

## Test plan

All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4.

1. **Reset values.** Hold `rst_n`=0 for 5 cycles → `tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0. Release reset with no pushes → `tx` stays 1 for 100 cycles.
2. **Single byte.** Push 0x4B once → `tx` falls 1 cycle after the push. The bench samples `tx` mid-bit and reads 0, 1,1,0,1,0,0,1,0, 1 (start, then LSB first, then stop), each bit 4 cycles wide. `busy` is high for exactly 40 cycles.
3. **Back-to-back and fill.** Push 0x55, 0xAA, 0x00, 0xFF, 0x31 in consecutive cycles.
   - The FIFO reaches level 4 with `in_ready`=0.
   - Bytes are accepted or refused per the `in_ready` rule, with nothing lost silently.
   - Accepted bytes appear on `tx` in order with no idle cycles between frames.
   - Total `busy` time is 40 × (bytes accepted) cycles.
4. **Push while full with a simultaneous pop.** Hold the FIFO at level 4 when a frame boundary pop occurs, with `in_valid`=1 → the push is refused that cycle and `fifo_level` drops to 3. The push is accepted on the next cycle.
5. **ena gating.** Drop `ena` during the data bits of the first of two queued bytes → the first frame completes intact. The second byte stays queued (`fifo_level`=1) until `ena` returns, then starts 1 cycle later.
6. **Reset mid-frame.** Assert `rst_n`=0 during bit 3 of a frame with 2 bytes queued → `tx`=1 immediately (within the same cycle). After release, `fifo_level`=0, `busy`=0, and no residual frame is emitted.
